// File: rtl/sat_arith_pkg.sv
// Shared definitions for the signed saturating arithmetic units (adder and serial subtractor).
// Holds the sequencer state type and the saturation-limit helpers.
package sat_arith_pkg;

    localparam int unsigned DefaultWidth = 4;
    localparam int unsigned MaxWidth     = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StSat   = 2'd2
    } sat_state_e;

    // Most positive value of a width-bit two's-complement number, zero-extended to MaxWidth.
    function automatic logic [MaxWidth-1:0] sat_max(input int unsigned width);
        logic [MaxWidth-1:0] v;
        v = '0;
        for (int i = 0; i < MaxWidth; i++) begin
            if (i < int'(width) - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Most negative value of a width-bit two's-complement number, zero-extended to MaxWidth.
    function automatic logic [MaxWidth-1:0] sat_min(input int unsigned width);
        logic [MaxWidth-1:0] v;
        v = '0;
        for (int i = 0; i < MaxWidth; i++) begin
            if (i == int'(width) - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/fs_cell.sv
// 1-bit full subtractor: diff = a - b - borrow-in, with borrow-out.
module fs_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic brw,
    output logic diff_i,
    output logic brw_next
);

    always_comb begin
        diff_i   = a_i ^ b_i ^ brw;
        brw_next = (~a_i & b_i) | (~(a_i ^ b_i) & brw);
    end

endmodule

// File: rtl/serial_sat_sub.sv
// Bit-serial signed saturating subtractor: result = a - b - bin, one bit per clock, LSB first.
// A single fs_cell is reused every SHIFT cycle; a final SAT cycle applies the clamp.
module serial_sat_sub
    import sat_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0]  LastBit = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SatMax  = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SatMin  = WIDTH'(sat_min(WIDTH));

    sat_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] a_q, b_q, part_q, result_q;
    logic             brw_q, a_msb_q, b_msb_in_q, bout_raw_q;
    logic             bout_q, ovf_q, done_q;
    logic             diff_bit, brw_nxt, last_bit, ov;

    fs_cell u_fs_cell (
        .a_i      (a_q[0]),
        .b_i      (b_q[0]),
        .brw      (brw_q),
        .diff_i   (diff_bit),
        .brw_next (brw_nxt)
    );

    assign last_bit = (cnt_q == LastBit);
    // Borrow into the MSB differing from borrow out of it is exactly signed overflow.
    assign ov       = b_msb_in_q ^ bout_raw_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start) state_d = StShift;
            end
            StShift: begin
                busy = 1'b1;
                if (last_bit) state_d = StSat;
            end
            StSat: begin
                busy    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            part_q     <= '0;
            brw_q      <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_in_q <= 1'b0;
            bout_raw_q <= 1'b0;
            result_q   <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        brw_q   <= bin;
                        a_msb_q <= a[WIDTH-1];
                        cnt_q   <= '0;
                    end
                end
                StShift: begin
                    a_q    <= a_q >> 1;
                    b_q    <= b_q >> 1;
                    brw_q  <= brw_nxt;
                    part_q <= {diff_bit, part_q[WIDTH-1:1]};
                    cnt_q  <= cnt_q + CntW'(1);
                    if (last_bit) begin
                        b_msb_in_q <= brw_q;
                        bout_raw_q <= brw_nxt;
                    end
                end
                StSat: begin
                    result_q <= ov ? (a_msb_q ? SatMin : SatMax) : part_q;
                    bout_q   <= bout_raw_q;
                    ovf_q    <= ov;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign bout   = bout_q;
    assign ovf    = ovf_q;

endmodule

// File: doc/serial_sat_sub.md
Name: serial_sat_sub

Overview:
Bit-serial signed saturating subtractor. It is the inverse-direction companion of the team's parallel 4-bit signed saturating adder, and computes result = a - b - bin with two's-complement saturation on signed overflow. It processes one bit per clock, LSB first, behind a start/ready/done handshake. It sits beside the adder in the ALU datapath and trades area for WIDTH+1 cycles of latency.

Parameters:
WIDTH, 4, operand and result width in bits; legal range 2..16.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only when ready=1.
a  input  WIDTH  minuend, two's complement; captured on accept.
b  input  WIDTH  subtrahend, two's complement; captured on accept.
bin  input  1  borrow-in; captured on accept.
ready  output  1  high in IDLE only.
busy  output  1  high in SHIFT and SAT.
done  output  1  one-cycle pulse when result, bout and ovf update.
result  output  WIDTH  saturated difference; held until the next done.
bout  output  1  raw unsigned borrow-out of the MSB stage (not saturated).
ovf  output  1  signed overflow occurred; result was saturated.

Behaviour:
- Reset, async on rst_n=0:
  - state=IDLE, ready=1, busy=0, done=0.
  - result=0, bout=0, ovf=0.
  - bit counter=0; operand shift registers and borrow register all 0.
- Reset asserted mid-operation aborts the operation; no done is produced.
- IDLE:
  - start=1 at edge E0: capture a, b, and bin into the borrow register; counter=0; go to SHIFT.
  - ready falls and busy rises after E0.
- SHIFT, one bit per edge:
  - diff_i = a_i ^ b_i ^ brw.
  - brw_next = (~a_i & b_i) | (~(a_i ^ b_i) & brw).
  - diff_i shifts into the partial-result register MSB-first so that bit 0 lands at position 0 after WIDTH shifts.
  - Counter increments each edge.
  - At the MSB step (counter=WIDTH-1), also latch the borrow into the MSB stage (b_msb_in) and the final borrow-out.
  - Go to SAT at edge E0+WIDTH.
- SAT, edge E0+WIDTH+1:
  - ov = b_msb_in XOR borrow-out, equivalent to (a_msb != b_msb) && (raw_msb != a_msb).
  - ov=1: result = a_msb ? {1, WIDTH-1 zeros} (most negative) : {0, WIDTH-1 ones} (most positive).
  - ov=0: result = raw difference.
  - ovf=ov; bout = raw borrow-out; done=1 for exactly this one cycle; go to IDLE (ready=1 in the same cycle done=1).
- Latency: done is asserted in the cycle following edge E0+WIDTH+1, i.e. WIDTH+1 clocks after accept.
- start while busy: ignored, with no queuing.
- start held high continuously: a new accept occurs on the first edge in IDLE, giving back-to-back throughput of one operation per WIDTH+2 cycles.
- a, b, bin may change freely after accept; the captured copies are used.
- result, bout and ovf change only at the done edge or on reset.
- bin=1 with a=b gives all-ones (-1), bout=1, ovf=0.

Decomposition:
- Shared package sat_arith_pkg:
  - state enum {IDLE, SHIFT, SAT}.
  - Functions sat_max(WIDTH) and sat_min(WIDTH).
  - Default-width constant, shared with the adder.
- One natural combinational sub-module, fs_cell: a 1-bit full subtractor with inputs a_i, b_i, brw and outputs diff_i, brw_next. It is instantiated once and reused each SHIFT cycle.

Test Plan:
1. WIDTH=4: a=0101, b=0011, bin=0 -> done after 5 clocks; result=0010, bout=0, ovf=0.
2. a=0011, b=0101, bin=0 -> result=1110 (-2), bout=1, ovf=0.
3. a=0111, b=1111 (7-(-1)) -> ovf=1, result=0111, bout=1.
4. a=1000, b=0001 (-8-1) -> ovf=1, result=1000, bout=0. Also a=0000, b=0000, bin=1 -> result=1111, bout=1, ovf=0.
5. Pulse start again 2 cycles after accept with different operands -> ignored; the first operation's result is delivered; ready stays 0 until the done cycle.
6. Drop rst_n during SHIFT (counter=2) -> outputs clear immediately and no done pulse. After release, start with a=0110, b=0010 -> result=0100 after 5 clocks. A prior result held across idle cycles must not change without done.
